tb_input_conditioner: RTL and testbench

Front-end stage for the Thunderbird tail-light controller. It synchronises and debounces the raw driver switches (left, right, brake, hazard, running light), resolves conflicting switch combinations into one legal command set, and generates the `dimclk` dimming clock. Its registered outputs drive the `left`/`right`/`brk`/`hzd` inputs of the `state` sequencer and the `dimclk`/`rlight` inputs of the `combination` output stage.

---
 rtl/tb_input_conditioner.sv | 149 ++++++++++++++
 tb/tb_tb_input_conditioner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_input_conditioner.sv
// Thunderbird tail-light front end: synchronises and debounces the five driver
// switches, resolves turn/hazard conflicts and generates the dimming clock.
module tb_input_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int DIM_DIV    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic left_raw,
    input  logic right_raw,
    input  logic brk_raw,
    input  logic hzd_raw,
    input  logic rlight_raw,
    output logic left,
    output logic right,
    output logic brk,
    output logic hzd,
    output logic rlight,
    output logic dimclk
);

    localparam logic [3:0] DEB_LAST = 4'(DEB_CYCLES - 1);
    localparam logic [7:0] DIM_LAST = 8'(DIM_DIV - 1);

    // Channel bit order: 0 left, 1 right, 2 brk, 3 hzd, 4 rlight
    logic [4:0] raw_s;
    logic [4:0] sync1_r;
    logic [4:0] sync2_r;
    logic [4:0] stable_r;
    logic [4:0] stable_nxt_s;
    logic [3:0] deb_cnt_r     [5];
    logic [3:0] deb_cnt_nxt_s [5];

    logic       hzd_s;
    logic       left_s;
    logic       right_s;
    logic       left_r;
    logic       right_r;
    logic       brk_r;
    logic       hzd_r;
    logic       rlight_r;

    logic [7:0] dim_cnt_r;
    logic [7:0] dim_cnt_nxt_s;
    logic       dimclk_r;
    logic       dimclk_nxt_s;

    assign raw_s = {rlight_raw, hzd_raw, brk_raw, right_raw, left_raw};

    // Two-flop synchroniser for the asynchronous switch levels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 5'b00000;
            sync2_r <= 5'b00000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce next state: accept a new level after DEB_CYCLES disagreeing cycles
    always_comb begin
        stable_nxt_s = stable_r;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_nxt_s[i] = 4'd0;
            if (sync2_r[i] != stable_r[i]) begin
                if (deb_cnt_r[i] >= DEB_LAST) begin
                    stable_nxt_s[i]  = sync2_r[i];
                    deb_cnt_nxt_s[i] = 4'd0;
                end else begin
                    deb_cnt_nxt_s[i] = deb_cnt_r[i] + 4'd1;
                end
            end else begin
                deb_cnt_nxt_s[i] = 4'd0;
            end
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable_r <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_r[i] <= 4'd0;
            end
        end else begin
            stable_r <= stable_nxt_s;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_r[i] <= deb_cnt_nxt_s[i];
            end
        end
    end

    // Left and right together are treated as a hazard request
    always_comb begin
        hzd_s   = stable_r[3] | (stable_r[0] & stable_r[1]);
        left_s  = stable_r[0] & ~hzd_s;
        right_s = stable_r[1] & ~hzd_s;
    end

    // Registered command outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            left_r   <= 1'b0;
            right_r  <= 1'b0;
            brk_r    <= 1'b0;
            hzd_r    <= 1'b0;
            rlight_r <= 1'b0;
        end else begin
            left_r   <= left_s;
            right_r  <= right_s;
            brk_r    <= stable_r[2];
            hzd_r    <= hzd_s;
            rlight_r <= stable_r[4];
        end
    end

    // Dim divider next state: wrap at DIM_DIV-1 and toggle dimclk on the wrap
    always_comb begin
        dim_cnt_nxt_s = dim_cnt_r;
        dimclk_nxt_s  = dimclk_r;
        if (dim_cnt_r >= DIM_LAST) begin
            dim_cnt_nxt_s = 8'd0;
            dimclk_nxt_s  = ~dimclk_r;
        end else begin
            dim_cnt_nxt_s = dim_cnt_r + 8'd1;
            dimclk_nxt_s  = dimclk_r;
        end
    end

    // Dim divider registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dim_cnt_r <= 8'd0;
            dimclk_r  <= 1'b0;
        end else begin
            dim_cnt_r <= dim_cnt_nxt_s;
            dimclk_r  <= dimclk_nxt_s;
        end
    end

    assign left   = left_r;
    assign right  = right_r;
    assign brk    = brk_r;
    assign hzd    = hzd_r;
    assign rlight = rlight_r;
    assign dimclk = dimclk_r;

endmodule

// File: tb/tb_tb_input_conditioner.sv
// Bench for tb_input_conditioner: defaults instance plus a DEB_CYCLES=1 /
// DIM_DIV=1 instance, checked against a sample-history reference model.
module tb_tb_input_conditioner;

    localparam int DEB0 = 4;
    localparam int DIM0 = 3;
    localparam int DEB1 = 1;
    localparam int DIM1 = 1;
    localparam int HLEN = 16384;

    logic clk = 1'b0;
    logic rst;
    logic left_raw, right_raw, brk_raw, hzd_raw, rlight_raw;
    logic l0, r0, b0, h0, rl0, d0;
    logic l1, r1, b1, h1, rl1, d1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tb_input_conditioner #(.DEB_CYCLES(DEB0), .DIM_DIV(DIM0)) dut0 (
        .clk(clk), .rst(rst),
        .left_raw(left_raw), .right_raw(right_raw), .brk_raw(brk_raw),
        .hzd_raw(hzd_raw), .rlight_raw(rlight_raw),
        .left(l0), .right(r0), .brk(b0), .hzd(h0), .rlight(rl0), .dimclk(d0)
    );

    tb_input_conditioner #(.DEB_CYCLES(DEB1), .DIM_DIV(DIM1)) dut1 (
        .clk(clk), .rst(rst),
        .left_raw(left_raw), .right_raw(right_raw), .brk_raw(brk_raw),
        .hzd_raw(hzd_raw), .rlight_raw(rlight_raw),
        .left(l1), .right(r1), .brk(b1), .hzd(h1), .rlight(rl1), .dimclk(d1)
    );

    // Output bundle order: {dimclk, rlight, hzd, brk, right, left}
    logic [5:0] dut_out [2];
    assign dut_out[0] = {d0, rl0, h0, b0, r0, l0};
    assign dut_out[1] = {d1, rl1, h1, b1, r1, l1};

    // Reference model state: raw samples per edge since reset release
    logic [4:0] samp [HLEN];
    int         k;
    logic [4:0] m_stable [2];
    int         m_flip   [2][5];
    logic [5:0] m_out    [2];

    typedef struct {
        logic [4:0] raw;   // {rlight, hzd, brk, right, left}
        logic [4:0] exp;   // {rlight, hzd, brk, right, left}
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk6(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int deb_of(input int i);
        return (i == 0) ? DEB0 : DEB1;
    endfunction

    function automatic int dim_of(input int i);
        return (i == 0) ? DIM0 : DIM1;
    endfunction

    function automatic logic [4:0] samp_at(input int idx);
        if (idx < 0) return 5'b00000;
        return samp[idx];
    endfunction

    function automatic logic [4:0] resolve(input logic [4:0] st);
        logic hz;
        hz = st[3] | (st[0] & st[1]);
        return {st[4], hz, st[2], st[1] & ~hz, st[0] & ~hz};
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < 2; i++) begin
            m_stable[i] = 5'b00000;
            m_out[i]    = 6'b000000;
            for (int c = 0; c < 5; c++) m_flip[i][c] = -100000;
        end
    endtask

    function automatic logic [4:0] raw_vec();
        return {rlight_raw, hzd_raw, brk_raw, right_raw, left_raw};
    endfunction

    task automatic set_raw(input logic [4:0] v);
        {rlight_raw, hzd_raw, brk_raw, right_raw, left_raw} = v;
    endtask

    // One clock edge: record the raw levels, advance the model, compare both DUTs.
    // A channel's stable bit flips at edge k when the last d synchronised samples
    // all disagree with it and none of them predates the previous flip.
    task automatic tick();
        logic [4:0] new_st;
        logic [4:0] s;
        logic       all_diff;
        int         d;
        if (k < HLEN) samp[k] = raw_vec();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            d = deb_of(i);
            m_out[i] = {1'(((k + 1) / dim_of(i)) % 2), resolve(m_stable[i])};
            new_st = m_stable[i];
            for (int c = 0; c < 5; c++) begin
                if ((k - d) >= m_flip[i][c]) begin
                    all_diff = 1'b1;
                    for (int j = k - d - 1; j <= k - 2; j++) begin
                        s = samp_at(j);
                        if (s[c] == m_stable[i][c]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        new_st[c]    = ~m_stable[i][c];
                        m_flip[i][c] = k;
                    end
                end
            end
            m_stable[i] = new_st;
        end
        k++;
        chk6("model_inst0", dut_out[0], m_out[0]);
        chk6("model_inst1", dut_out[1], m_out[1]);
    endtask

    task automatic do_reset(input int cycles, input bit scramble);
        #2;
        rst = 1'b0;
        #1;
        chk6("reset_async_inst0", dut_out[0], 6'b000000);
        chk6("reset_async_inst1", dut_out[1], 6'b000000);
        for (int n = 0; n < cycles; n++) begin
            if (scramble) set_raw(5'($urandom));
            @(posedge clk);
            #1;
            chk6("reset_hold_inst0", dut_out[0], 6'b000000);
            chk6("reset_hold_inst1", dut_out[1], 6'b000000);
        end
        rst = 1'b1;
        model_reset();
    endtask

    vec_t vecs [8];

    initial begin
        bit [0:6] dim_pat;
        vecs[0] = '{raw: 5'b00000, exp: 5'b00000};
        vecs[1] = '{raw: 5'b00001, exp: 5'b00001};
        vecs[2] = '{raw: 5'b00010, exp: 5'b00010};
        vecs[3] = '{raw: 5'b00011, exp: 5'b01000};
        vecs[4] = '{raw: 5'b00111, exp: 5'b01100};
        vecs[5] = '{raw: 5'b01001, exp: 5'b01000};
        vecs[6] = '{raw: 5'b10110, exp: 5'b10110};
        vecs[7] = '{raw: 5'b11111, exp: 5'b11100};

        rst = 1'b0;
        set_raw(5'b00000);
        model_reset();

        // Reset with scrambled inputs, then dimclk phase after release
        @(posedge clk);
        #1;
        do_reset(10, 1'b1);
        set_raw(5'b00000);
        dim_pat = 7'b0011100;
        for (int t = 0; t < 7; t++) begin
            tick();
            chk1("dimclk_after_release", d0, dim_pat[t]);
        end

        // Clean left press and release
        left_raw = 1'b1;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk1("left_press_latency", l0, t >= 6);
            chk6("left_press_others", {1'b0, rl0, h0, b0, r0, 1'b0}, 6'b000000);
        end
        left_raw = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk1("left_release_latency", l0, t < 6);
        end

        // Brake bounce: 3 high, 1 low, then steady high
        for (int t = 0; t < 12; t++) begin
            brk_raw = (t == 3) ? 1'b0 : 1'b1;
            tick();
            chk1("brk_bounce", b0, t >= 10);
        end
        brk_raw = 1'b0;
        repeat (8) tick();

        // Left and right together become hazard without a turn pulse
        left_raw  = 1'b1;
        right_raw = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk1("conflict_no_left", l0, 1'b0);
            chk1("conflict_no_right", r0, 1'b0);
            chk1("conflict_hzd", h0, t >= 6);
        end
        right_raw = 1'b0;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk1("drop_right_hzd", h0, t < 6);
            chk1("drop_right_left", l0, t >= 6);
        end
        left_raw = 1'b0;
        repeat (8) tick();

        // Brake with hazard, then asynchronous reset mid-debounce
        hzd_raw = 1'b1;
        brk_raw = 1'b1;
        repeat (8) tick();
        chk6("brk_hzd_settle", {1'b0, 1'b0, h0, b0, r0, l0}, 6'b001100);
        left_raw = 1'b1;
        repeat (3) tick();
        do_reset(2, 1'b0);
        for (int t = 0; t < 8; t++) begin
            tick();
            chk1("post_reset_hzd", h0, t >= 6);
            chk1("post_reset_brk", b0, t >= 6);
        end
        set_raw(5'b00000);
        repeat (8) tick();

        // Single-cycle pulse: accepted only by the DEB_CYCLES=1 instance
        rlight_raw = 1'b1;
        for (int t = 0; t < 7; t++) begin
            tick();
            rlight_raw = 1'b0;
            chk1("pulse_deb1", rl1, t == 3);
            chk1("pulse_deb4", rl0, 1'b0);
        end

        // Conflict-resolution table
        foreach (vecs[v]) begin
            set_raw(vecs[v].raw);
            repeat (DEB0 + 4) tick();
            chk6("table_inst0", {1'b0, dut_out[0][4:0]}, {1'b0, vecs[v].exp});
            chk6("table_inst1", {1'b0, dut_out[1][4:0]}, {1'b0, vecs[v].exp});
        end
        set_raw(5'b00000);
        repeat (8) tick();

        // Randomised bouncing switches against the reference model
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) do_reset(3, 1'b1);
            for (int c = 0; c < 5; c++) begin
                logic [4:0] v;
                v = raw_vec();
                if ($urandom_range(0, 5) == 0) v[c] = ~v[c];
                set_raw(v);
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
